// File: rtl/y86_fetch_decode.sv
// y86_fetch_decode: Y86-64 fetch+decode stage with byte instruction memory and 15-entry register file
module y86_fetch_decode #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc,
  input  logic        imem_we,
  input  logic [63:0] imem_waddr,
  input  logic [7:0]  imem_wdata,
  input  logic        wb_en,
  input  logic [3:0]  wb_dst,
  input  logic [63:0] wb_data,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] val_c,
  output logic [63:0] val_p,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  output logic        instr_valid,
  output logic        imem_error,
  output logic        halt
);
  localparam int AW = $clog2(IMEM_BYTES);
  logic [7:0]  imem [IMEM_BYTES];
  logic [63:0] regs [15];
  logic [7:0]  fb [10];
  logic [9:0]  inRange;
  logic [3:0]  icodeN, ifunN, raN, rbN, srcA, srcB, lenN;
  logic        hasRegs, hasC10, hasC9, errN;
  logic [63:0] valCN;
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      inRange[k] = (pc + 64'(k)) < 64'(IMEM_BYTES);
      fb[k] = inRange[k] ? imem[AW'(pc + 64'(k))] : 8'h00;
    end
  end
  assign icodeN  = fb[0][7:4];
  assign ifunN   = fb[0][3:0];
  assign hasRegs = icodeN inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
  assign hasC10  = icodeN inside {4'h3, 4'h4, 4'h5};
  assign hasC9   = icodeN inside {4'h7, 4'h8};
  assign lenN    = hasC10 ? 4'd10 : hasC9 ? 4'd9 : hasRegs ? 4'd2 : 4'd1;
  assign raN     = hasRegs ? fb[1][7:4] : 4'hF;
  assign rbN     = hasRegs ? fb[1][3:0] : 4'hF;
  assign valCN   = hasC10 ? {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2]}
                 : hasC9  ? {fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1]} : 64'd0;
  assign srcA    = (icodeN inside {4'h2, 4'h4, 4'h6, 4'hA}) ? raN
                 : (icodeN inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
  assign srcB    = (icodeN inside {4'h4, 4'h5, 4'h6}) ? rbN
                 : (icodeN inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
  // Only bytes that belong to the instruction count towards the range error
  always_comb begin
    errN = 1'b0;
    for (int k = 0; k < 10; k++)
      if (4'(k) < lenN && !inRange[k]) errN = 1'b1;
  end
  always_ff @(posedge clk)
    if (!rst && imem_we && imem_waddr < 64'(IMEM_BYTES)) imem[AW'(imem_waddr)] <= imem_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      icode       <= 4'h0;
      ifun        <= 4'h0;
      ra          <= 4'hF;
      rb          <= 4'hF;
      val_c       <= 64'd0;
      val_p       <= 64'd0;
      val_a       <= 64'd0;
      val_b       <= 64'd0;
      instr_valid <= 1'b0;
      imem_error  <= 1'b0;
      halt        <= 1'b0;
      for (int i = 0; i < 15; i++) regs[i] <= 64'(i);
    end else begin
      icode       <= icodeN;
      ifun        <= ifunN;
      ra          <= raN;
      rb          <= rbN;
      val_c       <= valCN;
      val_p       <= pc + 64'(lenN);
      val_a       <= srcA == 4'hF ? 64'd0 : regs[srcA];
      val_b       <= srcB == 4'hF ? 64'd0 : regs[srcB];
      instr_valid <= icodeN <= 4'hB;
      imem_error  <= errN;
      halt        <= icodeN == 4'h0;
      if (wb_en && wb_dst != 4'hF) regs[wb_dst] <= wb_data;
    end
  end
endmodule

// File: tb/tb_y86_fetch_decode.sv
// tb_y86_fetch_decode: directed fetch/decode vectors with hand-computed expectations
module tb_y86_fetch_decode;
  logic        clk = 1'b0;
  logic        rst, imem_we, wb_en;
  logic [63:0] pc, imem_waddr, wb_data;
  logic [7:0]  imem_wdata;
  logic [3:0]  wb_dst;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] val_c, val_p, val_a, val_b;
  logic        instr_valid, imem_error, halt;
  int errors = 0;
  int checks = 0;
  logic [7:0] prog [30] = '{
    8'h30, 8'hF3, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h60, 8'h23, 8'hA0, 8'h6F, 8'h90,
    8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h20, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00};
  y86_fetch_decode dut (
    .clk(clk), .rst(rst), .pc(pc), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data),
    .icode(icode), .ifun(ifun), .ra(ra), .rb(rb), .val_c(val_c), .val_p(val_p),
    .val_a(val_a), .val_b(val_b), .instr_valid(instr_valid), .imem_error(imem_error),
    .halt(halt));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic load(input logic [63:0] a, input logic [7:0] d);
    imem_we = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    tick();
    imem_we = 1'b0;
  endtask
  task automatic fetch(input logic [63:0] a);
    pc = a;
    tick();
  endtask
  initial begin
    rst = 1'b1; imem_we = 1'b0; wb_en = 1'b0; pc = '0;
    imem_waddr = '0; imem_wdata = '0; wb_dst = 4'hF; wb_data = '0;
    tick();
    check("rst_icode", 64'(icode), 64'h0);
    check("rst_ra", 64'(ra), 64'hF);
    check("rst_rb", 64'(rb), 64'hF);
    check("rst_valp", val_p, 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) load(64'(i), prog[i]);
    load(64'd1022, 8'h30);
    load(64'd1023, 8'hF3);
    fetch(64'd0);
    check("irm_icode", 64'(icode), 64'h3);
    check("irm_ifun", 64'(ifun), 64'h0);
    check("irm_ra", 64'(ra), 64'hF);
    check("irm_rb", 64'(rb), 64'h3);
    check("irm_valc", val_c, 64'h100);
    check("irm_valp", val_p, 64'd10);
    check("irm_vala", val_a, 64'd0);
    check("irm_valb", val_b, 64'd0);
    check("irm_valid", 64'(instr_valid), 64'd1);
    check("irm_err", 64'(imem_error), 64'd0);
    fetch(64'd10);
    check("add_icode", 64'(icode), 64'h6);
    check("add_ra", 64'(ra), 64'h2);
    check("add_rb", 64'(rb), 64'h3);
    check("add_vala", val_a, 64'd2);
    check("add_valb", val_b, 64'd3);
    check("add_valp", val_p, 64'd12);
    fetch(64'd12);
    check("push_vala", val_a, 64'd6);
    check("push_valb", val_b, 64'd4);
    check("push_valp", val_p, 64'd14);
    fetch(64'd14);
    check("ret_vala", val_a, 64'd4);
    check("ret_valb", val_b, 64'd4);
    check("ret_valp", val_p, 64'd15);
    check("ret_ra", 64'(ra), 64'hF);
    fetch(64'd15);
    check("call_valc", val_c, 64'h40);
    check("call_valp", val_p, 64'd24);
    check("call_valb", val_b, 64'd4);
    check("call_vala", val_a, 64'd0);
    // writeback on the same edge as the decode read: old value seen
    wb_en = 1'b1; wb_dst = 4'd2; wb_data = 64'h55;
    fetch(64'd24);
    check("raw_old_vala", val_a, 64'd2);
    wb_en = 1'b0;
    fetch(64'd24);
    check("rr_icode", 64'(icode), 64'h2);
    check("rr_vala", val_a, 64'h55);
    check("rr_rb", 64'(rb), 64'h3);
    check("rr_valb", val_b, 64'd0);
    wb_en = 1'b1; wb_dst = 4'hF; wb_data = 64'h99;
    fetch(64'd10);
    wb_en = 1'b0;
    fetch(64'd10);
    check("nowb_vala", val_a, 64'h55);
    check("nowb_valb", val_b, 64'd3);
    // imem write and fetch of that byte on the same edge: old byte fetched
    imem_we = 1'b1; imem_waddr = 64'd26; imem_wdata = 8'hC0;
    fetch(64'd26);
    imem_we = 1'b0;
    check("wrsame_halt", 64'(halt), 64'd1);
    fetch(64'd26);
    check("inv_valid", 64'(instr_valid), 64'd0);
    check("inv_valp", val_p, 64'd27);
    check("inv_icode", 64'(icode), 64'hC);
    check("inv_halt", 64'(halt), 64'd0);
    fetch(64'd28);
    check("halt_halt", 64'(halt), 64'd1);
    check("halt_valp", val_p, 64'd29);
    check("halt_valid", 64'(instr_valid), 64'd1);
    fetch(64'd1022);
    check("edge_err", 64'(imem_error), 64'd1);
    check("edge_icode", 64'(icode), 64'h3);
    check("edge_valp", val_p, 64'd1032);
    fetch(64'd1020);
    check("inrange_err", 64'(imem_error), 64'd0);
    fetch(64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_err", 64'(imem_error), 64'd1);
    check("wrap_halt", 64'(halt), 64'd1);
    check("wrap_valp", val_p, 64'd0);
    // reset mid-stream beats a concurrent register write
    pc = 64'd10; rst = 1'b1; wb_en = 1'b1; wb_dst = 4'd3; wb_data = 64'h77;
    tick();
    rst = 1'b0; wb_en = 1'b0;
    check("mid_icode", 64'(icode), 64'h0);
    check("mid_ra", 64'(ra), 64'hF);
    check("mid_rb", 64'(rb), 64'hF);
    check("mid_vala", val_a, 64'd0);
    check("mid_valp", val_p, 64'd0);
    fetch(64'd10);
    check("post_vala", val_a, 64'd2);
    check("post_valb", val_b, 64'd3);
    check("post_valp", val_p, 64'd12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
